line_sensor_conditioner: RTL and testbench

Front-end stage between the three raw IR line sensors and the crossing counter / line-follow FSM. It synchronises the asynchronous sensor inputs and debounces them as one 3-bit vector, so the downstream stages never see single-sensor glitches or torn patterns. It also generates two supervision signals from the clean vector:
- `timeout_crossing_fix`: a one-cycle pulse when the robot sits on an all-black (000) pattern too long.
- `line_lost`: a level that is high while the robot has seen all-white (111) for too long.

---
 rtl/line_sensor_pkg.sv | 11 +
 rtl/pattern_persist_timer.sv | 42 ++++
 rtl/line_sensor_conditioner.sv | 91 +++++++++
 tb/tb_line_sensor_conditioner.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/line_sensor_pkg.sv
// Shared types and pattern constants for the line sensor front end.
// Sensor polarity: 0 = line (black), 1 = floor (white). Vector order {l, m, r}.
package line_sensor_pkg;

    typedef logic [2:0] sensor_vec_t;

    localparam sensor_vec_t PAT_CROSSING  = 3'b000;  // all three on the line
    localparam sensor_vec_t PAT_ON_LINE   = 3'b101;  // centred on the line
    localparam sensor_vec_t PAT_ALL_WHITE = 3'b111;  // no line visible

endpackage

// File: rtl/pattern_persist_timer.sv
// Counts consecutive cycles on which `match` is high and flags when the
// run reaches N cycles.
//   clk, reset : clock, synchronous active-high reset
//   match      : the watched pattern is present this cycle
//   clr        : synchronous clear of the count and the output
//   out        : PULSE=1 -> one-cycle pulse per match run
//                PULSE=0 -> level, high while the run has lasted >= N cycles
module pattern_persist_timer #(
    parameter int N     = 20,
    parameter bit PULSE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic match,
    input  logic clr,
    output logic out
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] SAT  = CW'(N);

    logic [CW-1:0] cnt;

    // The counter parks at N once reached, so the terminal compare can only
    // succeed once per run: that is what limits pulse mode to one pulse.
    always_ff @(posedge clk) begin
        if (reset || clr || !match) begin
            cnt <= '0;
            out <= 1'b0;
        end else if (cnt == LAST) begin
            cnt <= SAT;
            out <= 1'b1;
        end else if (cnt == SAT) begin
            out <= !PULSE;
        end else begin
            cnt <= cnt + CW'(1);
            out <= 1'b0;
        end
    end

endmodule

// File: rtl/line_sensor_conditioner.sv
// Front end for the three IR line sensors: two-flop synchroniser, joint
// 3-bit debounce, and two supervision timers on the filtered vector.
//   clk, reset           : clock, synchronous active-high reset
//   clr_timers           : synchronous clear of both supervision timers
//   sensor_*_raw         : asynchronous raw sensors (0 = line)
//   sensor_l/m/r         : filtered sensors
//   sensor_changed       : one-cycle pulse when the filtered vector changes
//   timeout_crossing_fix : one-cycle pulse after TIMEOUT_CYCLES of 000
//   line_lost            : level, high while 111 has lasted >= LOST_CYCLES
module line_sensor_conditioner
    import line_sensor_pkg::*;
#(
    parameter int STABLE_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 25_000_000,
    parameter int LOST_CYCLES    = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_timers,
    input  logic sensor_l_raw,
    input  logic sensor_m_raw,
    input  logic sensor_r_raw,
    output logic sensor_l,
    output logic sensor_m,
    output logic sensor_r,
    output logic sensor_changed,
    output logic timeout_crossing_fix,
    output logic line_lost
);

    localparam int DW = $clog2(STABLE_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(STABLE_CYCLES - 1);

    sensor_vec_t   sync1, sync2, cand, filt;
    logic [DW-1:0] db_cnt;

    // The whole vector is debounced as one word so a pattern change that
    // arrives skewed across sensors never shows up as an intermediate pattern.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1          <= PAT_ALL_WHITE;
            sync2          <= PAT_ALL_WHITE;
            cand           <= PAT_ALL_WHITE;
            filt           <= PAT_ALL_WHITE;
            db_cnt         <= '0;
            sensor_changed <= 1'b0;
        end else begin
            sync1          <= {sensor_l_raw, sensor_m_raw, sensor_r_raw};
            sync2          <= sync1;
            sensor_changed <= 1'b0;
            if (sync2 != cand) begin
                cand   <= sync2;
                db_cnt <= DW'(1);
            end else if (db_cnt == DB_LAST) begin
                // Counter holds here; re-loading the same value is harmless
                // and only a real change raises sensor_changed.
                filt           <= cand;
                sensor_changed <= (cand != filt);
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

    assign sensor_l = filt[2];
    assign sensor_m = filt[1];
    assign sensor_r = filt[0];

    pattern_persist_timer #(
        .N     (TIMEOUT_CYCLES),
        .PULSE (1'b1)
    ) u_crossing_timer (
        .clk   (clk),
        .reset (reset),
        .match (filt == PAT_CROSSING),
        .clr   (clr_timers),
        .out   (timeout_crossing_fix)
    );

    pattern_persist_timer #(
        .N     (LOST_CYCLES),
        .PULSE (1'b0)
    ) u_lost_timer (
        .clk   (clk),
        .reset (reset),
        .match (filt == PAT_ALL_WHITE),
        .clr   (clr_timers),
        .out   (line_lost)
    );

endmodule

// File: tb/tb_line_sensor_conditioner.sv
// Directed bench for line_sensor_conditioner with STABLE=4, TIMEOUT=20, LOST=30.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_line_sensor_conditioner;

    logic clk = 1'b0;
    logic reset, clr_timers;
    logic sensor_l_raw, sensor_m_raw, sensor_r_raw;
    logic sensor_l, sensor_m, sensor_r;
    logic sensor_changed, timeout_crossing_fix, line_lost;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    line_sensor_conditioner #(
        .STABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (20),
        .LOST_CYCLES    (30)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .clr_timers           (clr_timers),
        .sensor_l_raw         (sensor_l_raw),
        .sensor_m_raw         (sensor_m_raw),
        .sensor_r_raw         (sensor_r_raw),
        .sensor_l             (sensor_l),
        .sensor_m             (sensor_m),
        .sensor_r             (sensor_r),
        .sensor_changed       (sensor_changed),
        .timeout_crossing_fix (timeout_crossing_fix),
        .line_lost            (line_lost)
    );

    wire [2:0] filt = {sensor_l, sensor_m, sensor_r};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_raw(input logic [2:0] v);
        {sensor_l_raw, sensor_m_raw, sensor_r_raw} = v;
    endtask

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        reset      = 1'b1;
        clr_timers = 1'b0;
        set_raw(3'b111);
        step(); step(); step();
        chk3("rst_filt", filt, 3'b111);
        chk1("rst_changed", sensor_changed, 1'b0);
        chk1("rst_fix", timeout_crossing_fix, 1'b0);
        chk1("rst_lost", line_lost, 1'b0);

        // 1: raw 101 captured at E0, visible after E0+5
        reset = 1'b0;
        set_raw(3'b101);
        for (int i = 1; i <= 7; i++) begin
            step();
            chk3("t1_filt", filt, (i >= 6) ? 3'b101 : 3'b111);
            chk1("t1_changed", sensor_changed, i == 6);
        end

        // 2: 3-cycle glitch on the middle sensor is rejected
        set_raw(3'b111);
        step(); step(); step();
        set_raw(3'b101);
        for (int i = 1; i <= 10; i++) begin
            step();
            chk3("t2_filt", filt, 3'b101);
            chk1("t2_changed", sensor_changed, 1'b0);
        end

        // 3: long crossing -> exactly one pulse after 20 filtered-000 cycles
        set_raw(3'b000);
        for (int i = 1; i <= 40; i++) begin
            step();
            chk1("t3_fix", timeout_crossing_fix, i == 26);
            if (i == 5) chk3("t3_filt_pre", filt, 3'b101);
            if (i == 6) begin
                chk3("t3_filt", filt, 3'b000);
                chk1("t3_changed", sensor_changed, 1'b1);
            end
        end

        // 4: short 000 episode (10 cycles) then a full one
        set_raw(3'b101);
        for (int i = 1; i <= 10; i++) begin
            step();
            chk1("t4_fix_a", timeout_crossing_fix, 1'b0);
        end
        chk3("t4_filt_a", filt, 3'b101);
        set_raw(3'b000);
        for (int i = 1; i <= 10; i++) begin
            step();
            chk1("t4_fix_b", timeout_crossing_fix, 1'b0);
        end
        set_raw(3'b101);
        for (int i = 1; i <= 10; i++) begin
            step();
            chk1("t4_fix_c", timeout_crossing_fix, 1'b0);
            if (i == 5) chk3("t4_filt_b", filt, 3'b000);
            if (i == 6) chk3("t4_filt_c", filt, 3'b101);
        end
        set_raw(3'b000);
        for (int i = 1; i <= 35; i++) begin
            step();
            chk1("t4_fix_d", timeout_crossing_fix, i == 26);
        end

        // 5a: all-white -> line_lost 30 cycles after filtered 111
        set_raw(3'b111);
        for (int i = 1; i <= 40; i++) begin
            step();
            chk1("t5_lost", line_lost, i >= 36);
            chk1("t5_fix", timeout_crossing_fix, 1'b0);
        end
        // 5b: back on line -> drops one edge after filtered becomes 101
        set_raw(3'b101);
        for (int i = 1; i <= 8; i++) begin
            step();
            chk1("t5_lost_drop", line_lost, i <= 6);
            if (i == 6) chk3("t5_filt", filt, 3'b101);
        end
        // 5c: clear at filtered-111 cycle 25 postpones line_lost by 25
        set_raw(3'b111);
        for (int i = 1; i <= 65; i++) begin
            clr_timers = (i == 31);
            step();
            chk1("t5_lost_clr", line_lost, i >= 61);
        end
        clr_timers = 1'b0;

        // 6a: reset mid-debounce (candidate 000, cnt 2) while line_lost high
        set_raw(3'b000);
        step(); step(); step(); step();
        reset = 1'b1;
        step();
        chk3("t6_filt", filt, 3'b111);
        chk1("t6_changed", sensor_changed, 1'b0);
        chk1("t6_lost", line_lost, 1'b0);
        chk1("t6_fix", timeout_crossing_fix, 1'b0);

        // 6b: reset lands on the edge the timeout pulse would fire
        reset = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            step();
            chk1("t6_fix_pre", timeout_crossing_fix, 1'b0);
            if (i == 6) chk3("t6_filt_000", filt, 3'b000);
        end
        reset = 1'b1;
        step();
        chk1("t6_fix_rst", timeout_crossing_fix, 1'b0);
        chk3("t6_filt_rst", filt, 3'b111);
        chk1("t6_changed_rst", sensor_changed, 1'b0);
        step();
        chk1("t6_fix_rst2", timeout_crossing_fix, 1'b0);
        reset = 1'b0;
        set_raw(3'b111);
        step(); step();
        chk3("t6_filt_post", filt, 3'b111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
